// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin arbiter sharing one W-bit down-counter among NREQ one-shot delay requesters.
// Grant at edge E with delay D gives a done pulse after E+D+1; requesters hold req (level) until done or abort.
module delay_scheduler #(
  parameter int  NREQ = 4,
  parameter int  W    = 8,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] delay_in,
  input  logic              abort,
  output logic              busy,
  output logic [IW-1:0]     grant_id,
  output logic [W-1:0]      count,
  output logic [NREQ-1:0]   done,
  output logic              aborted
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_gid, w_gid_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [W-1:0]    r_count, w_count_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_aborted, w_aborted_nxt;

  logic [IW-1:0]   w_win;
  logic [W-1:0]    w_win_dly;
  logic            w_win_vld;

  // Search starts one past the last grant, so every held request is served within NREQ grants.
  always_comb begin
    w_win     = '0;
    w_win_dly = '0;
    w_win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_win_vld && req[(int'(r_last) + k) % NREQ]) begin
        w_win_vld = 1'b1;
        w_win     = IW'((int'(r_last) + k) % NREQ);
        w_win_dly = delay_in[((int'(r_last) + k) % NREQ) * W +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gid_nxt     = r_gid;
    w_last_nxt    = r_last;
    w_count_nxt   = r_count;
    w_done_nxt    = '0;
    w_aborted_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_COUNT;
          w_gid_nxt   = w_win;
          w_count_nxt = w_win_dly;
        end
      end
      S_COUNT: begin
        // Cancel outranks completion, so aborted and done can never coincide.
        if (abort || !req[r_gid]) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
          w_last_nxt    = r_gid;
        end else if (r_count == '0) begin
          w_state_nxt        = S_DONE;
          w_done_nxt[r_gid]  = 1'b1;
        end else begin
          w_count_nxt = r_count - W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_gid;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_gid     <= '0;
      r_last    <= IW'(NREQ - 1);
      r_count   <= '0;
      r_done    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gid     <= w_gid_nxt;
      r_last    <= w_last_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_gid;
  assign count    = r_count;
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: job-level reference model checked every cycle, plus directed literal checks.
module tb_delay_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [NREQ*W-1:0] delay_in = '0;
  logic              abort    = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;
  logic [W-1:0]      count;
  logic [NREQ-1:0]   done;
  logic              aborted;

  int checks   = 0;
  int failures = 0;
  bit auto_drop = 1'b1;

  always #5 clk = ~clk;

  delay_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .delay_in (delay_in),
    .abort    (abort),
    .busy     (busy),
    .grant_id (grant_id),
    .count    (count),
    .done     (done),
    .aborted  (aborted)
  );

  // Reference model: a job is (owner, delay D, edges elapsed since grant); phase 0 idle, 1 running, 2 finishing.
  int              m_phase = 0, m_id = 0, m_last = NREQ - 1, m_d = 0, m_el = 0;
  logic [NREQ-1:0] m_done  = '0;
  logic            m_ab    = 1'b0;
  int              n_phase, n_id, n_last, n_d, n_el;
  logic [NREQ-1:0] n_done;
  logic            n_ab;
  bit              n_found;

  always_comb begin
    n_phase = m_phase;
    n_id    = m_id;
    n_last  = m_last;
    n_d     = m_d;
    n_el    = m_el;
    n_done  = '0;
    n_ab    = 1'b0;
    n_found = 1'b0;
    if (m_phase == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!n_found && req[(m_last + k) % NREQ]) begin
          n_found = 1'b1;
          n_id    = (m_last + k) % NREQ;
        end
      end
      if (n_found) begin
        n_phase = 1;
        n_d     = int'(delay_in[n_id*W +: W]);
        n_el    = 0;
      end
    end else if (m_phase == 1) begin
      if (abort || !req[m_id]) begin
        n_phase = 0;
        n_ab    = 1'b1;
        n_last  = m_id;
      end else if (m_el == m_d) begin
        n_phase      = 2;
        n_done[m_id] = 1'b1;
      end else begin
        n_el = m_el + 1;
      end
    end else begin
      n_phase = 0;
      n_last  = m_id;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_id    <= 0;
      m_last  <= NREQ - 1;
      m_d     <= 0;
      m_el    <= 0;
      m_done  <= '0;
      m_ab    <= 1'b0;
    end else begin
      m_phase <= n_phase;
      m_id    <= n_id;
      m_last  <= n_last;
      m_d     <= n_d;
      m_el    <= n_el;
      m_done  <= n_done;
      m_ab    <= n_ab;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",     int'(busy),     int'(m_phase != 0));
    chk("grant_id", int'(grant_id), m_id);
    chk("count",    int'(count),    m_d - m_el);
    chk("done",     int'(done),     int'(m_done));
    chk("aborted",  int'(aborted),  int'(m_ab));
  end

  // Advance one cycle; inputs change 1 ns after the falling edge, clear of the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
    if (auto_drop) req = req & ~m_done;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    abort = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  int n;
  int ng;
  int order [4];
  bit prev_busy;

  initial begin
    step();
    step();
    chk("rst_busy",    int'(busy),     0);
    chk("rst_count",   int'(count),    0);
    chk("rst_gid",     int'(grant_id), 0);
    chk("rst_done",    int'(done),     0);
    chk("rst_aborted", int'(aborted),  0);
    reset = 1'b1;
    step();

    // 1: req[0], D=5
    delay_in[7:0] = 8'd5;
    req = 4'b0001;
    step();
    chk("t1_busy", int'(busy), 1);
    chk("t1_load", int'(count), 5);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t1_count", int'(count), 5 - i);
      chk("t1_nodone", int'(done), 0);
    end
    step();
    chk("t1_done", int'(done), 4'b0001);
    step();
    chk("t1_idle", int'(busy), 0);
    chk("t1_done_1cyc", int'(done), 0);

    // 2: D=0 on req[2]
    delay_in[23:16] = 8'd0;
    req = 4'b0100;
    step();
    chk("t2_gid", int'(grant_id), 2);
    chk("t2_cnt", int'(count), 0);
    step();
    chk("t2_done", int'(done), 4'b0100);
    chk("t2_cnt0", int'(count), 0);
    step();
    chk("t2_idle", int'(busy), 0);

    // 3: all requesting, D=3 each
    do_reset();
    delay_in = {8'd3, 8'd3, 8'd3, 8'd3};
    req = 4'b1111;
    n = 0;
    ng = 0;
    prev_busy = busy;
    while (req != 0 && n < 60) begin
      step();
      n++;
      if (busy && !prev_busy && ng < 4) begin
        order[ng] = int'(grant_id);
        ng++;
      end
      prev_busy = busy;
    end
    chk("t3_ngrants", ng, 4);
    chk("t3_steps", n, 23);
    chk("t3_order0", order[0], 0);
    chk("t3_order1", order[1], 1);
    chk("t3_order2", order[2], 2);
    chk("t3_order3", order[3], 3);
    step();

    // 4: abort at the edge where count is 0
    do_reset();
    delay_in = {8'd0, 8'd0, 8'd1, 8'd2};
    req = 4'b0011;
    step();
    step();
    step();
    chk("t4_pre_cnt", int'(count), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_aborted", int'(aborted), 1);
    chk("t4_nodone", int'(done), 0);
    chk("t4_idle", int'(busy), 0);
    step();
    chk("t4_next_gid", int'(grant_id), 1);
    chk("t4_next_cnt", int'(count), 1);
    req = 4'b0010;
    step();
    step();
    chk("t4_done1", int'(done), 4'b0010);
    step();

    // 5a: granted requester drops req at count=7
    delay_in[31:24] = 8'd20;
    req = 4'b1000;
    step();
    chk("t5a_gid", int'(grant_id), 3);
    chk("t5a_load", int'(count), 20);
    repeat (13) step();
    chk("t5a_cnt7", int'(count), 7);
    req = 4'b0000;
    step();
    chk("t5a_aborted", int'(aborted), 1);
    chk("t5a_nodone", int'(done), 0);
    step();
    chk("t5a_ab_1cyc", int'(aborted), 0);

    // 5b: delay_in changes mid-count
    delay_in[15:8] = 8'd10;
    req = 4'b0010;
    step();
    n = 1;
    chk("t5b_load", int'(count), 10);
    step();
    step();
    n = 3;
    delay_in = 32'hC8C8_C8C8;
    while (done == 0 && n < 40) begin
      step();
      n++;
    end
    chk("t5b_done_at", n, 12);
    chk("t5b_done", int'(done), 4'b0010);
    step();

    // 6: async reset at count=100, then full-width delay
    delay_in[23:16] = 8'd100;
    req = 4'b0100;
    step();
    chk("t6_cnt100", int'(count), 100);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy",  int'(busy),     0);
    chk("t6_rst_count", int'(count),    0);
    chk("t6_rst_gid",   int'(grant_id), 0);
    chk("t6_rst_done",  int'(done),     0);
    chk("t6_rst_ab",    int'(aborted),  0);
    req = '0;
    step();
    step();
    reset = 1'b1;
    step();
    delay_in[15:8] = 8'd255;
    req = 4'b0010;
    step();
    n = 1;
    chk("t6_load255", int'(count), 255);
    while (done == 0 && n < 300) begin
      step();
      n++;
    end
    chk("t6_done_at", n, 257);
    chk("t6_done", int'(done), 4'b0010);
    step();
    chk("t6_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
